// File: rtl/laa_ctrl.sv
// laa_ctrl: decodes custom-0 LAA instructions, owns an NREGS x XLEN register file and
// runs an iterative shift-add multiplier. Optional MAC instruction: define LAA_MAC_EN.
module laa_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter logic [6:0]  OPCODE = 7'b0001011
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ins_valid,
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] rs1_data,
    output logic            ins_ready,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_ins,
    output logic            busy,
    output logic            dbg_state
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [4:0] F_READ  = 5'd1;
    localparam logic [4:0] F_WRITE = 5'd2;
    localparam logic [4:0] F_MUL   = 5'd3;
`ifdef LAA_MAC_EN
    localparam logic [4:0] F_MAC   = 5'd4;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_d;
    logic [XLEN-1:0] acc_init;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   dest_q;

    logic [4:0]      funct;
    logic [4:0]      f_src;
    logic [4:0]      f_dst;
    logic [4:0]      f_a;
    logic [4:0]      f_b;
    logic            is_ours;
    logic            accept;
    logic            dec_read;
    logic            dec_write;
    logic            dec_mul;
    logic            dec_mac;
    logic            dec_illegal;
    logic [XLEN-1:0] src_val;
    logic [XLEN-1:0] a_val;
    logic [XLEN-1:0] b_val;

    // Index fields are always 5 bits wide; anything past the regfile is illegal.
    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    always_comb begin
        funct   = ins[11:7];
        f_src   = ins[31:27];
        f_dst   = ins[26:22];
        f_a     = ins[21:17];
        f_b     = ins[16:12];
        is_ours = (ins[6:0] == OPCODE);

        dec_read  = is_ours && (funct == F_READ)  && idx_ok(f_src);
        dec_write = is_ours && (funct == F_WRITE) && idx_ok(f_dst);
        dec_mul   = is_ours && (funct == F_MUL)
                    && idx_ok(f_dst) && idx_ok(f_a) && idx_ok(f_b);
`ifdef LAA_MAC_EN
        dec_mac   = is_ours && (funct == F_MAC)
                    && idx_ok(f_dst) && idx_ok(f_a) && idx_ok(f_b);
        acc_init  = dec_mac ? regs_q[f_dst[AW-1:0]] : '0;
`else
        dec_mac   = 1'b0;
        acc_init  = '0;
`endif
        dec_illegal = is_ours && !(dec_read || dec_write || dec_mul || dec_mac);

        src_val = regs_q[f_src[AW-1:0]];
        a_val   = regs_q[f_a[AW-1:0]];
        b_val   = regs_q[f_b[AW-1:0]];

        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign ins_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = ins_valid && ins_ready;
    assign dbg_state = (state_q == ST_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            dest_q      <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            illegal_ins <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            illegal_ins <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (dec_write) begin
                            regs_q[f_dst[AW-1:0]] <= rs1_data;
                        end
                        if (dec_read) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= f_dst;
                            wb_data  <= src_val;
                        end
                        if (dec_mul || dec_mac) begin
                            mcand_q  <= a_val;
                            mplier_q <= b_val;
                            acc_q    <= acc_init;
                            cnt_q    <= '0;
                            dest_q   <= f_dst[AW-1:0];
                            busy     <= 1'b1;
                            state_q  <= ST_MUL;
                        end
                        if (dec_illegal) begin
                            illegal_ins <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    // Last step: the final partial product goes straight into the regfile.
                    if (cnt_q == CW'(XLEN - 1)) begin
                        regs_q[dest_q] <= acc_d;
                        busy           <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laa_ctrl.sv
// tb_laa_ctrl: table-driven vectors plus hand-written multi-cycle sequences for laa_ctrl,
// with a writeback scoreboard. Expectations follow LAA_MAC_EN if it is defined.
module tb_laa_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 8;
    localparam logic [6:0]  OP    = 7'b0001011;
    localparam logic [6:0]  OP_RV = 7'b0110011;

    localparam logic [4:0] F_READ  = 5'd1;
    localparam logic [4:0] F_WRITE = 5'd2;
    localparam logic [4:0] F_MUL   = 5'd3;
    localparam logic [4:0] F_MAC   = 5'd4;
    localparam logic [4:0] F_BAD   = 5'd7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ins_valid = 1'b0;
    logic [31:0]     ins = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic            ins_ready;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal_ins;
    logic            busy;
    logic            dbg_state;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rs1;
        logic        exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t        vecs[$];
    logic [36:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ill_seen = 0;
    int          ill_exp = 0;

    laa_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .OPCODE(OP)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins(ins), .rs1_data(rs1_data),
        .ins_ready(ins_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal_ins(illegal_ins), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_op(input logic [4:0] f, input logic [4:0] src,
                                           input logic [4:0] dst, input logic [4:0] a,
                                           input logic [4:0] b, input logic [6:0] op);
        return {src, dst, a, b, f, op};
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] f, input logic [4:0] src,
                                        input logic [4:0] dst, input logic [4:0] a,
                                        input logic [4:0] b);
        return enc_op(f, src, dst, a, b, OP);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] w, input logic [31:0] d, input logic wb,
                           input logic [4:0] rd, input logic [31:0] data, input logic ill);
        vec_t v;
        v.ins = w; v.rs1 = d; v.exp_wb = wb; v.exp_rd = rd; v.exp_data = data; v.exp_ill = ill;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [31:0] w, input logic [31:0] d);
        int guard;
        guard = 0;
        ins_valid = 1'b1;
        ins = w;
        rs1_data = d;
        while (!ins_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: ins_ready stayed 0 for %0d cycles, expected 1", guard);
        end
        @(negedge clk);
        ins_valid = 1'b0;
    endtask

    task automatic read_expect(input logic [4:0] src, input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
        issue(enc(F_READ, src, rd, 5'd0, 5'd0), '0);
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got pulse rd=%0d data=0x%0h, expected none", wb_rd, wb_data);
            end else begin
                check("wb_rd_data", {wb_rd, wb_data}, exp_q.pop_front());
            end
        end
        if (!rst && illegal_ins) ill_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, prod;
        int cyc;

        repeat (2) @(negedge clk);
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_wb_rd", wb_rd, 5'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_illegal", illegal_ins, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", ins_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", ins_ready, 1'b1);

        ra = $urandom;
        rb = $urandom_range(1, 32'hFFFF);
        prod = ra * rb;

        add_vec(enc(F_READ, 5'd5, 5'd10, 0, 0), 0, 1, 5'd10, 32'd0, 0);
        add_vec(enc(F_WRITE, 0, 5'd1, 0, 0), 32'd7, 0, 0, 0, 0);
        add_vec(enc(F_WRITE, 0, 5'd2, 0, 0), 32'd6, 0, 0, 0, 0);
        add_vec(enc(F_MUL, 0, 5'd3, 5'd1, 5'd2), 0, 0, 0, 0, 0);
        add_vec(enc(F_READ, 5'd3, 5'd4, 0, 0), 0, 1, 5'd4, 32'd42, 0);
        add_vec(enc(F_WRITE, 0, 5'd1, 0, 0), 32'h0001_0000, 0, 0, 0, 0);
        add_vec(enc(F_MUL, 0, 5'd3, 5'd1, 5'd1), 0, 0, 0, 0, 0);
        add_vec(enc(F_READ, 5'd3, 5'd7, 0, 0), 0, 1, 5'd7, 32'h0000_0000, 0);
        add_vec(enc(F_WRITE, 0, 5'd1, 0, 0), 32'hFFFF_FFFF, 0, 0, 0, 0);
        add_vec(enc(F_WRITE, 0, 5'd2, 0, 0), 32'd2, 0, 0, 0, 0);
        add_vec(enc(F_MUL, 0, 5'd4, 5'd1, 5'd2), 0, 0, 0, 0, 0);
        add_vec(enc(F_READ, 5'd4, 5'd8, 0, 0), 0, 1, 5'd8, 32'hFFFF_FFFE, 0);
        add_vec(enc(F_BAD, 0, 5'd4, 5'd1, 5'd2), 32'd99, 0, 0, 0, 1);
        add_vec(enc(F_READ, 5'd4, 5'd9, 0, 0), 0, 1, 5'd9, 32'hFFFF_FFFE, 0);
        add_vec(enc_op(F_WRITE, 0, 5'd4, 0, 0, OP_RV), 32'd123, 0, 0, 0, 0);
        add_vec(enc(F_READ, 5'd4, 5'd1, 0, 0), 0, 1, 5'd1, 32'hFFFF_FFFE, 0);
        add_vec(enc(F_WRITE, 0, 5'd9, 0, 0), 32'd55, 0, 0, 0, 1);
        add_vec(enc(F_WRITE, 0, 5'd8, 0, 0), 32'd56, 0, 0, 0, 1);
        add_vec(enc(F_MUL, 0, 5'd2, 5'd9, 5'd1), 0, 0, 0, 0, 1);
        add_vec(enc(F_READ, 5'd8, 5'd3, 0, 0), 0, 0, 0, 0, 1);
        add_vec(enc(F_READ, 5'd1, 5'd2, 0, 0), 0, 1, 5'd2, 32'hFFFF_FFFF, 0);
        add_vec(enc(F_READ, 5'd0, 5'd2, 0, 0), 0, 1, 5'd2, 32'd0, 0);
        add_vec(enc(F_READ, 5'd2, 5'd31, 0, 0), 0, 1, 5'd31, 32'd2, 0);
        add_vec(enc(F_WRITE, 0, 5'd6, 0, 0), ra, 0, 0, 0, 0);
        add_vec(enc(F_WRITE, 0, 5'd7, 0, 0), rb, 0, 0, 0, 0);
        add_vec(enc(F_MUL, 0, 5'd6, 5'd6, 5'd7), 0, 0, 0, 0, 0);
        add_vec(enc(F_READ, 5'd6, 5'd12, 0, 0), 0, 1, 5'd12, prod, 0);
        add_vec(enc(F_READ, 5'd7, 5'd13, 0, 0), 0, 1, 5'd13, rb, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].exp_wb) exp_q.push_back({vecs[i].exp_rd, vecs[i].exp_data});
            if (vecs[i].exp_ill) ill_exp++;
            issue(vecs[i].ins, vecs[i].rs1);
            check($sformatf("vec%0d_illegal", i), illegal_ins, vecs[i].exp_ill);
        end

        // Multiply latency: ready stays low for exactly XLEN cycles after acceptance.
        issue(enc(F_WRITE, 0, 5'd1, 0, 0), 32'd7);
        issue(enc(F_WRITE, 0, 5'd2, 0, 0), 32'd6);
        issue(enc(F_MUL, 0, 5'd3, 5'd1, 5'd2), 0);
        check("mul_busy", busy, 1'b1);
        check("mul_dbg_state", dbg_state, 1'b1);
        cyc = 0;
        while (!ins_ready && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("mul_ready_low_cycles", cyc, XLEN);
        check("mul_busy_clear", busy, 1'b0);
        read_expect(5'd3, 5'd4, 32'd42);

        // Reset during a multiply aborts it and clears the regfile.
        issue(enc(F_WRITE, 0, 5'd1, 0, 0), 32'd3);
        issue(enc(F_WRITE, 0, 5'd2, 0, 0), 32'd5);
        issue(enc(F_MUL, 0, 5'd3, 5'd1, 5'd2), 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", ins_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_ready", ins_ready, 1'b1);
        check("rst_release_busy", busy, 1'b0);
        @(negedge clk);
        read_expect(5'd3, 5'd5, 32'd0);
        read_expect(5'd1, 5'd6, 32'd0);
        repeat (XLEN + 4) @(negedge clk);
        read_expect(5'd3, 5'd5, 32'd0);

        // Multiply-accumulate, legal only when the MAC datapath is built.
        issue(enc(F_WRITE, 0, 5'd3, 0, 0), 32'd100);
        issue(enc(F_WRITE, 0, 5'd1, 0, 0), 32'd7);
        issue(enc(F_WRITE, 0, 5'd2, 0, 0), 32'd6);
`ifdef LAA_MAC_EN
        issue(enc(F_MAC, 0, 5'd3, 5'd1, 5'd2), 0);
        check("mac_illegal", illegal_ins, 1'b0);
        read_expect(5'd3, 5'd11, 32'd142);
`else
        ill_exp++;
        issue(enc(F_MAC, 0, 5'd3, 5'd1, 5'd2), 0);
        check("mac_illegal", illegal_ins, 1'b1);
        read_expect(5'd3, 5'd11, 32'd100);
`endif

        repeat (4) @(negedge clk);
        check("wb_queue_empty", exp_q.size(), 0);
        check("illegal_pulse_count", ill_seen, ill_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
